// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: 8N1 UART receiver for a command channel.
// A 2-flop synchronizer feeds a five-state receive FSM (IDLE, START, DATA,
// STOP, BREAK). Good bytes are delivered through a DataOut/DataReady
// handshake. DataValid, FramingError and Overrun are single-cycle event pulses.
`timescale 1ns/1ps
module uart_cmd_rx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       sdi_i,
  input  logic       read_strobe_i,
  output logic [7:0] data_out_o,
  output logic       data_ready_o,
  output logic       data_valid_o,
  output logic       framing_error_o,
  output logic       overrun_o,
  output logic       busy_o
);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  // Start-bit midpoint and full-bit terminal counts. The counter is cleared
  // at every terminal count, so it never wraps within a state.
  localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);

  logic       sdi_meta_q, sdi_s_q;
  state_t     state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] data_q, data_d;
  logic       ready_q, ready_d;
  logic       valid_q, valid_d;
  logic       ferr_q, ferr_d;
  logic       ovr_q, ovr_d;
  logic       accept;

  // Bring the asynchronous serial line into the clock domain. Both flops
  // reset to the idle-high level, so a reset does not look like a start edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sdi_meta_q <= 1'b1;
      sdi_s_q    <= 1'b1;
    end else begin
      sdi_meta_q <= sdi_i;
      sdi_s_q    <= sdi_meta_q;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 16'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      data_q  <= 8'h00;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  // Next-state logic: frame sequencing, then the delivery handshake.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    ready_d = ready_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    accept  = 1'b0;

    case (state_q)
      IDLE: begin
        if (!sdi_s_q) begin
          state_d = START;
          cnt_d   = 16'd0;
        end
      end
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = 16'd0;
          if (!sdi_s_q) begin
            state_d = DATA;
            bit_d   = 3'd0;
          end else begin
            // The line went back high before mid start bit, so treat it as a glitch.
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = 16'd0;
          shift_d = {sdi_s_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = 16'd0;
          if (sdi_s_q) begin
            accept  = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      BREAK: begin
        // Wait out a held-low line. New start edges are not detected here.
        cnt_d = 16'd0;
        if (sdi_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // If a read happens in the same cycle as an accept, the slot is free for
    // the new byte. Without that read, an unread byte is kept and the new one is lost.
    if (accept) begin
      if (!ready_q || read_strobe_i) begin
        data_d  = shift_q;
        ready_d = 1'b1;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (read_strobe_i) begin
      ready_d = 1'b0;
    end
  end

  assign data_out_o      = data_q;
  assign data_ready_o    = ready_q;
  assign data_valid_o    = valid_q;
  assign framing_error_o = ferr_q;
  assign overrun_o       = ovr_q;
  assign busy_o          = (state_q != IDLE);

endmodule
